// File: rtl/cam_capture_pkg.sv
// Shared definitions for the camera capture path and its frame-buffer neighbours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: capture FSM state encoding, default geometry, IMG_SIZE (the reserved black-pixel slot).
package cam_capture_pkg;

   typedef enum logic [1:0] {
      WAIT_VS    = 2'd0,
      WAIT_FRAME = 2'd1,
      CAPTURE    = 2'd2
   } state_t;

   localparam int AW_DEF     = 15;
   localparam int DW_DEF     = 12;
   localparam int WIDTH_DEF  = 160;
   localparam int HEIGHT_DEF = 120;

   // First address past the image; the buffer keeps it as the black pixel
   // and the VGA path reads it outside the active picture.
   localparam int IMG_SIZE = WIDTH_DEF * HEIGHT_DEF;

endpackage

// File: rtl/cam_capture_sync_edge.sv
// Rise/fall detector: one registered copy of a signal already in the clk domain.
// Latency: edges are combinational against the registered copy (same-cycle detect).
// Backpressure: none.
// Ports: clk, rst_n (async active-low), sig in; rise/fall single-cycle strobes out.
module sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic rise,
   output logic fall
);

   logic prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev <= 1'b0;
      else        prev <= sig;
   end

   assign rise = sig & ~prev;
   assign fall = ~sig & prev;

endmodule

// File: rtl/cam_capture.sv
// OV7670 RGB444 byte-stream deserialiser and frame-buffer write-port driver.
// Latency: write strobe one clk_w after the second byte of a pixel; frame_done one clk_w after vsync rise.
// Backpressure: none; the buffer must accept one write per two clk_w cycles.
// Ports: clk_w, reset (async active-low), capture_en, vsync, href, px_data in;
//        addr_in/data_in/regwrite (buffer write port), frame_done/frame_err out.
module cam_capture
   import cam_capture_pkg::*;
#(
   parameter int AW     = AW_DEF,
   parameter int DW     = DW_DEF,
   parameter int WIDTH  = WIDTH_DEF,
   parameter int HEIGHT = HEIGHT_DEF
) (
   input  logic          clk_w,
   input  logic          reset,
   input  logic          capture_en,
   input  logic          vsync,
   input  logic          href,
   input  logic [7:0]    px_data,
   output logic [AW-1:0] addr_in,
   output logic [DW-1:0] data_in,
   output logic          regwrite,
   output logic          frame_done,
   output logic          frame_err
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int RW = $clog2(HEIGHT + 1);

   state_t        state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [AW-1:0] row_base;
   logic          phase;
   logic          err;
   logic [3:0]    red;

   logic vs_rise, vs_fall, href_fall, href_rise_unused;

   sync_edge u_vs_edge (
      .clk   (clk_w),
      .rst_n (reset),
      .sig   (vsync),
      .rise  (vs_rise),
      .fall  (vs_fall)
   );

   sync_edge u_href_edge (
      .clk   (clk_w),
      .rst_n (reset),
      .sig   (href),
      .rise  (href_rise_unused),
      .fall  (href_fall)
   );

   logic          col_open, row_open, eol, line_bad;
   logic [RW-1:0] row_after;

   assign col_open = (col < CW'(WIDTH));
   assign row_open = (row < RW'(HEIGHT));
   // vsync rising while href is still high closes the line in the same cycle.
   assign eol      = href_fall | (vs_rise & href);
   // Short line, dangling odd byte, or a line beyond the last row.
   assign line_bad = (col != CW'(WIDTH)) | phase | ~row_open;
   // Row count as it stands once this cycle's end-of-line is applied, so the
   // frame check sees the line check's effect first.
   assign row_after = (eol && row_open) ? row + RW'(1) : row;

   always_ff @(posedge clk_w or negedge reset) begin
      if (!reset) begin
         state      <= WAIT_VS;
         col        <= '0;
         row        <= '0;
         row_base   <= '0;
         phase      <= 1'b0;
         err        <= 1'b0;
         red        <= '0;
         addr_in    <= '0;
         data_in    <= '0;
         regwrite   <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         regwrite   <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            // Wait for blanking so capture always starts on a whole frame.
            WAIT_VS: begin
               if (vsync) state <= WAIT_FRAME;
            end
            WAIT_FRAME: begin
               if (vs_fall && capture_en) begin
                  state    <= CAPTURE;
                  col      <= '0;
                  row      <= '0;
                  row_base <= '0;
                  phase    <= 1'b0;
                  err      <= 1'b0;
               end
            end
            CAPTURE: begin
               if (eol) begin
                  if (line_bad) err <= 1'b1;
                  col   <= '0;
                  phase <= 1'b0;
                  if (row_open) begin
                     row      <= row + RW'(1);
                     row_base <= row_base + AW'(WIDTH);
                  end
               end else if (href) begin
                  if (!phase) begin
                     red   <= px_data[3:0];
                     phase <= 1'b1;
                  end else begin
                     phase <= 1'b0;
                     // Guarding on both bounds keeps every write below IMG_SIZE.
                     if (col_open && row_open) begin
                        regwrite <= 1'b1;
                        addr_in  <= row_base + AW'(col);
                        data_in  <= DW'({red, px_data});
                     end else begin
                        err <= 1'b1;
                     end
                     if (col_open) col <= col + CW'(1);
                  end
               end
               if (vs_rise) begin
                  frame_done <= 1'b1;
                  frame_err  <= err | (eol & line_bad) | (row_after != RW'(HEIGHT));
                  state      <= WAIT_FRAME;
               end
            end
            default: state <= WAIT_VS;
         endcase
      end
   end

endmodule

// File: tb/tb_cam_capture.sv
module tb_cam_capture;

   localparam int AW = 15;
   localparam int DW = 12;
   localparam int W  = 160;
   localparam int H  = 120;

   logic          clk_w = 1'b0;
   logic          reset = 1'b1;
   logic          capture_en = 1'b0;
   logic          vsync = 1'b0;
   logic          href = 1'b0;
   logic [7:0]    px_data = 8'h00;
   logic [AW-1:0] addr_in;
   logic [DW-1:0] data_in;
   logic          regwrite, frame_done, frame_err;

   cam_capture #(.AW(AW), .DW(DW), .WIDTH(W), .HEIGHT(H)) dut (
      .clk_w      (clk_w),
      .reset      (reset),
      .capture_en (capture_en),
      .vsync      (vsync),
      .href       (href),
      .px_data    (px_data),
      .addr_in    (addr_in),
      .data_in    (data_in),
      .regwrite   (regwrite),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   always #5 clk_w = ~clk_w;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      bit en;
      int nlines;
      int sl;       // line index with a non-nominal byte count (-1 = none)
      int sb;       // byte count of that line
      int mode;     // 0: constant 0x0A/0xBC pair, 1: pixel index pattern
      int exp_wr;
      int exp_done;
      int exp_err;
   } vec_t;

   wr_t  exp_q[$];
   wr_t  cur;
   vec_t vecs[6];
   int   checks = 0;
   int   errors = 0;
   int   wr_cnt = 0;
   int   done_cnt = 0;
   logic last_err = 1'b0;
   logic prev_wr = 1'b0;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Write monitor / scoreboard, sampled on the inactive edge.
   always @(negedge clk_w) begin
      if (regwrite) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual addr=%0d data=%h expected no write", addr_in, data_in);
         end else begin
            cur = exp_q.pop_front();
            check("wr_addr", int'(addr_in), int'(cur.addr));
            check("wr_data", int'(data_in), int'(cur.data));
         end
         check("wr_spacing_prev_wr", int'(prev_wr), 0);
      end
      prev_wr = regwrite;
      if (frame_done) begin
         done_cnt++;
         last_err = frame_err;
      end
   end

   task automatic tick(int n = 1);
      repeat (n) @(negedge clk_w);
   endtask

   // Drive one byte of line `row`, byte number b; push the expected write on the pixel's second byte.
   task automatic drive_byte(int b, int row, int mode, bit model);
      logic [11:0] pix;
      logic [3:0]  hi;
      int          idx;
      idx = row * W + b / 2;
      pix = (mode == 0) ? 12'hABC : idx[11:0];
      hi  = (mode == 0) ? 4'h0 : 4'h5;
      href = 1'b1;
      px_data = (b % 2 == 0) ? {hi, pix[11:8]} : pix[7:0];
      if (b % 2 == 1 && model && b / 2 < W && row < H)
         exp_q.push_back('{addr: AW'(idx), data: pix});
      tick();
   endtask

   task automatic send_line(int nbytes, int row, int mode, bit model);
      for (int b = 0; b < nbytes; b++) drive_byte(b, row, mode, model);
      href = 1'b0;
      px_data = 8'h00;
      tick(2);
   endtask

   // Expects vsync high on entry; leaves vsync high.
   task automatic run_frame(bit en, int nlines, int sl, int sb, int mode, bit model);
      capture_en = en;
      tick();
      vsync = 1'b0;
      tick(3);
      for (int i = 0; i < nlines; i++) send_line((i == sl) ? sb : 2 * W, i, mode, model & en);
      vsync = 1'b1;
      tick(4);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog timeout actual=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int w0, d0;

      vecs[0] = '{en: 1'b1, nlines: H, sl: -1, sb: 0,   mode: 0, exp_wr: 19200, exp_done: 1, exp_err: 0};
      vecs[1] = '{en: 1'b1, nlines: 4, sl: 1,  sb: 330, mode: 1, exp_wr: 640,   exp_done: 1, exp_err: 1};
      vecs[2] = '{en: 1'b1, nlines: 4, sl: 1,  sb: 318, mode: 1, exp_wr: 639,   exp_done: 1, exp_err: 1};
      vecs[3] = '{en: 1'b0, nlines: 4, sl: -1, sb: 0,   mode: 1, exp_wr: 0,     exp_done: 0, exp_err: 0};
      vecs[4] = '{en: 1'b1, nlines: 4, sl: 2,  sb: 321, mode: 1, exp_wr: 640,   exp_done: 1, exp_err: 1};
      vecs[5] = '{en: 1'b1, nlines: 3, sl: -1, sb: 0,   mode: 1, exp_wr: 480,   exp_done: 1, exp_err: 1};

      // Reset state.
      #1 reset = 1'b0;
      #2;
      check("rst_addr_in",    int'(addr_in),    0);
      check("rst_data_in",    int'(data_in),    0);
      check("rst_regwrite",   int'(regwrite),   0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_frame_err",  int'(frame_err),  0);
      tick(2);
      reset = 1'b1;
      tick(2);
      vsync = 1'b1;
      tick(4);

      for (int v = 0; v < 6; v++) begin
         w0 = wr_cnt;
         d0 = done_cnt;
         run_frame(vecs[v].en, vecs[v].nlines, vecs[v].sl, vecs[v].sb, vecs[v].mode, 1'b1);
         check($sformatf("v%0d_writes", v), wr_cnt - w0, vecs[v].exp_wr);
         check($sformatf("v%0d_done", v), done_cnt - d0, vecs[v].exp_done);
         if (vecs[v].exp_done != 0)
            check($sformatf("v%0d_frame_err", v), int'(last_err), vecs[v].exp_err);
         check($sformatf("v%0d_queue_left", v), exp_q.size(), 0);
      end

      // href activity during blanking is ignored.
      w0 = wr_cnt;
      for (int b = 0; b < 40; b++) begin
         href = 1'b1;
         px_data = 8'($urandom_range(0, 255));
         tick();
      end
      href = 1'b0;
      tick(3);
      check("blank_href_writes", wr_cnt - w0, 0);

      // Reset in the middle of line 50.
      capture_en = 1'b1;
      tick();
      vsync = 1'b0;
      tick(3);
      for (int i = 0; i < 50; i++) send_line(2 * W, i, 1, 1'b1);
      for (int b = 0; b < 41; b++) drive_byte(b, 50, 1, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("midrst_regwrite", int'(regwrite), 0);
      check("midrst_addr_in",  int'(addr_in),  0);
      check("midrst_data_in",  int'(data_in),  0);
      check("midrst_frame_err", int'(frame_err), 0);
      exp_q.delete();
      href = 1'b0;
      tick(3);
      reset = 1'b1;
      // Rest of the interrupted frame: vsync still low, must not be captured or completed.
      w0 = wr_cnt;
      d0 = done_cnt;
      for (int i = 51; i < 54; i++) send_line(2 * W, i, 1, 1'b0);
      vsync = 1'b1;
      tick(4);
      check("resync_writes", wr_cnt - w0, 0);
      check("resync_done",   done_cnt - d0, 0);

      // Next frame captures from address 0 again.
      w0 = wr_cnt;
      d0 = done_cnt;
      run_frame(1'b1, 3, -1, 0, 1, 1'b1);
      check("post_rst_writes", wr_cnt - w0, 480);
      check("post_rst_done",   done_cnt - d0, 1);
      check("post_rst_queue",  exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cam_capture.md
# cam_capture

Camera-side writer for the dual-port frame buffer. Deserialises the OV7670 byte stream (RGB444, two bytes per pixel, QQVGA 160x120) into 12-bit pixels. Produces write address, write data and write enable for the buffer's write port, all on the buffer's write clock. Frames are captured only when enabled; partial frames after reset are discarded. The first address past the image (WIDTH*HEIGHT) is never written; it stays reserved as the black pixel.

## Interface
- AW, 15, address width; must satisfy 2^AW > WIDTH*HEIGHT
- DW, 12, pixel width (RGB444)
- WIDTH, 160, pixels per line
- HEIGHT, 120, lines per frame

- clk_w  in  1  camera pixel clock; also drives buffer write port
- reset  in  1  asynchronous, active-low; all state and outputs cleared while low
- capture_en  in  1  sampled at frame start; 1 = capture next frame
- vsync  in  1  camera vertical sync, high during vertical blanking
- href  in  1  camera line valid, high while line bytes are on px_data
- px_data  in  8  camera byte
- addr_in  out  AW  buffer write address
- data_in  out  DW  buffer write data {R,G,B}
- regwrite  out  1  buffer write enable, one cycle per pixel
- frame_done  out  1  one-cycle pulse at end of a captured frame
- frame_err  out  1  valid with frame_done: 1 = geometry mismatch

## Operation
- States: WAIT_VS, WAIT_FRAME, CAPTURE.
- Reset -> WAIT_VS.
- WAIT_VS: wait for vsync=1 -> WAIT_FRAME. This guarantees resync to a full frame.
- WAIT_FRAME: on vsync 1->0, if capture_en=1 -> CAPTURE with row=0, col=0, row_base=0, phase=0, err=0. Otherwise stay in WAIT_FRAME and skip that frame.
- CAPTURE, href=1, each clk_w:
  - phase 0: latch R = px_data[3:0]; phase<=1.
  - phase 1: pixel = {R, px_data[7:4], px_data[3:0]}.
    - If col<WIDTH and row<HEIGHT: write it to row_base+col.
    - col<=col+1 (saturating at WIDTH); phase<=0.
- CAPTURE, href 1->0 (end of line):
  - If col != WIDTH or phase=1, err<=1.
  - col<=0; phase<=0 (an odd trailing byte is dropped).
  - If row<HEIGHT: row<=row+1 and row_base<=row_base+WIDTH (adder, no multiplier).
  - Lines past HEIGHT set err and write nothing.
- CAPTURE, vsync 0->1 (end of frame):
  - Pulse frame_done.
  - frame_err = err OR (row != HEIGHT).
  - Go to WAIT_FRAME.
- capture_en changes during CAPTURE are ignored until the next frame start.
- Address rule: writes only ever target 0..WIDTH*HEIGHT-1. Address WIDTH*HEIGHT is never written.

## Timing
- Edge detection on vsync and href uses one registered copy of each. An edge is acted on in the cycle it is detected.
- Outputs are registered. regwrite, addr_in and data_in are asserted in the cycle after the phase-1 byte is sampled, for exactly one cycle.
- Write spacing: at most one write per 2 clk_w cycles.
- frame_done is asserted in the cycle after vsync rising is detected. frame_err is valid in the same cycle and holds until the next frame_done.
- Reset values: addr_in=0, data_in=0, regwrite=0, frame_done=0, frame_err=0, state=WAIT_VS.
- Reset asserted mid-line: regwrite drops immediately (asynchronous). The interrupted frame is never completed, and frame_done is not pulsed for it.
- href high while in WAIT_VS or WAIT_FRAME: ignored.
- vsync rising while href=1: treated as end of line and end of frame in the same cycle. The line check runs first.

## Structure
- Shared package holds:
  - state encoding (WAIT_VS, WAIT_FRAME, CAPTURE);
  - WIDTH/HEIGHT defaults;
  - IMG_SIZE = WIDTH*HEIGHT, also used by the buffer's black-pixel slot and the VGA path.
- One natural sub-module: sync_edge, a registered rise/fall detector instantiated for vsync and href.
- Counter widths:
  - col: clog2(WIDTH+1)
  - row: clog2(HEIGHT+1)
  - row_base: AW

## Test plan
- Nominal frame: reset, capture_en=1, vsync pulse, then 120 lines of 320 bytes with byte pair (0x0A, 0xBC) -> 19200 writes.
  - Every write has data_in=12'hABC.
  - First write at addr 0; last at addr 19199.
  - frame_done pulses once with frame_err=0.
- Address mapping: byte pattern encodes the pixel index -> line 1, column 0 writes to addr 160; line 119, column 159 writes to addr 19199. No write ever reaches addr 19200.
- Long/short lines:
  - A line of 330 bytes -> only 160 writes, and frame_err=1.
  - A line of 318 bytes -> 159 writes, and frame_err=1.
  - The next line still starts at its correct row_base.
- Disabled/odd byte:
  - capture_en=0 at frame start -> no regwrite for the whole frame and no frame_done.
  - A line ending after an odd byte -> last byte dropped, frame_err=1.
- Reset mid-frame: assert reset at line 50 -> outputs go to 0 immediately. The next vsync low period is not captured until a full vsync high->low has been seen. The following frame captures normally from addr 0.
